// File: rtl/bg_rom_reader.sv
// rtl/bg_rom_reader.sv - background ROM row fetcher and MSB-first pixel serialiser
// One ROM row is fetched per line during horizontal blank and shifted out across the active line.
module bg_rom_reader #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 240,
  parameter int          IMG_H      = 256,
  parameter int          H_REP      = 1,
  parameter int          V_REP      = 1,
  parameter logic [23:0] FG_COLOR   = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR   = 24'h000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vs_in,
  input  logic                  hs_in,
  input  logic                  de_in,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  vs_out,
  output logic                  hs_out,
  output logic                  de_out,
  output logic [23:0]           rgb_out,
  output logic                  underrun
);

  localparam int              RW      = ADDR_WIDTH + 1;
  localparam int              BW      = $clog2(DATA_WIDTH + 1);
  localparam logic [RW-1:0]   IMG_H_R = RW'(IMG_H);
  localparam logic [2:0]      VMAX    = 3'(V_REP - 1);
  localparam logic [2:0]      HMAX    = 3'(H_REP - 1);
  localparam logic [BW-1:0]   BMAX    = BW'(DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LOAD} state_e;

  state_e                state_q;
  logic                  vs_q, de_q;
  logic [RW-1:0]         row_q, row_d;
  logic [2:0]            vrep_q, vrep_d;
  logic                  row_valid_q, row_valid_d;
  logic                  line_ok_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [2:0]            hrep_q;
  logic [BW-1:0]         bit_cnt_q;
  logic                  fetch_start;
  logic                  vs_rise, de_fall, de_rise, pix;

  assign vs_rise = vs_in & ~vs_q;
  assign de_fall = ~de_in & de_q;
  assign de_rise = de_in & ~de_q;
  assign pix     = shreg_q[DATA_WIDTH-1] & line_ok_q & row_valid_q & (bit_cnt_q < BMAX);

  // Row sequencing; line ends are ignored until a frame start has validated the row counter.
  always_comb begin
    row_d       = row_q;
    vrep_d      = vrep_q;
    row_valid_d = row_valid_q;
    fetch_start = 1'b0;
    if (vs_rise) begin
      row_d       = '0;
      vrep_d      = '0;
      row_valid_d = 1'b1;
      fetch_start = 1'b1;
    end else if (de_fall && row_valid_q) begin
      if (vrep_q == VMAX) begin
        vrep_d = '0;
        if (row_q != IMG_H_R) row_d = row_q + RW'(1);
      end else begin
        vrep_d = vrep_q + 3'(1);
      end
      if (row_d >= IMG_H_R) row_valid_d = 1'b0;
      else                  fetch_start = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vs_q        <= 1'b0;
      de_q        <= 1'b0;
      row_q       <= '0;
      vrep_q      <= '0;
      row_valid_q <= 1'b0;
      line_ok_q   <= 1'b0;
      shreg_q     <= '0;
      hrep_q      <= '0;
      bit_cnt_q   <= '0;
      rom_addr    <= '0;
      vs_out      <= 1'b0;
      hs_out      <= 1'b0;
      de_out      <= 1'b0;
      rgb_out     <= '0;
      underrun    <= 1'b0;
    end else begin
      vs_q        <= vs_in;
      de_q        <= de_in;
      vs_out      <= vs_in;
      hs_out      <= hs_in;
      de_out      <= de_in;
      rgb_out     <= de_in ? (pix ? FG_COLOR : BG_COLOR) : 24'h0;
      row_q       <= row_d;
      vrep_q      <= vrep_d;
      row_valid_q <= row_valid_d;

      if (de_in) begin
        if (hrep_q == HMAX) begin
          hrep_q  <= '0;
          shreg_q <= shreg_q << 1;
          if (bit_cnt_q != BMAX) bit_cnt_q <= bit_cnt_q + BW'(1);
        end else begin
          hrep_q <= hrep_q + 3'(1);
        end
      end else begin
        hrep_q    <= '0;
        bit_cnt_q <= '0;
      end

      // A load landing inside an active line belongs to an underrun line and must not unblank it.
      if (fetch_start) begin
        rom_addr <= row_d[ADDR_WIDTH-1:0];
        state_q  <= S_WAIT;
      end else begin
        case (state_q)
          S_WAIT: state_q <= S_LOAD;
          S_LOAD: begin
            shreg_q <= rom_data;
            if (!de_in) line_ok_q <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end

      if (vs_rise || de_fall) line_ok_q <= 1'b0;
      if (de_rise && (state_q != S_IDLE || fetch_start)) begin
        line_ok_q <= 1'b0;
        underrun  <= 1'b1;
      end
    end
  end

endmodule
